i2c_target_mem: RTL and testbench

//  I2C target (responder) with an internal 2**ADDRWIDTH x DATAWIDTH register file; the far end of the I2C initiator wrapper.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_cond.sv | 82 ++++++++
 rtl/i2c_target_mem.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target_mem.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register-file slice.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, DEV, DACK, REG, RACK, WR, WACK, RD, MACK, SKIP
  } i2c_tgt_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchronizer, optional glitch filter and edge/START/STOP detector.
// Define I2C_TGT_FILTER_EN to add a 3-sample majority filter on both lines.
module i2c_line_cond
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int unsigned WARM = SYNC_STAGES + 3;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [WARM-1:0]        warm_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_c, sda_c, armed;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      warm_q     <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      warm_q     <= {warm_q[WARM-2:0], 1'b1};
    end
  end

`ifdef I2C_TGT_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  // Edges are masked until the pipeline has flushed its reset values,
  // so a line held low across reset cannot fake a START.
  assign armed      = warm_q[WARM-1];
  assign sda_o      = sda_c;
  assign scl_rise_o = armed &  scl_c & ~scl_prev_q;
  assign scl_fall_o = armed & ~scl_c &  scl_prev_q;
  assign start_o    = armed & scl_c & scl_prev_q &  sda_prev_q & ~sda_c;
  assign stop_o     = armed & scl_c & scl_prev_q & ~sda_prev_q &  sda_c;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with an internal register file: pointer byte, auto-increment writes/reads.
// Optional glitch filter via I2C_TGT_FILTER_EN (inside i2c_line_cond).
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned ADDRWIDTH   = 6,
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 wr_strobe,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [DATAWIDTH-1:0] wr_data,
  output logic                 busy
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam logic [3:0]  BITS  = 4'(DATAWIDTH);

  logic sda_lvl, scl_rise, scl_fall, start, stop;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_tgt_state_e         state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]   shreg_q, shreg_d;
  logic [ADDRWIDTH-1:0]   ptr_q, ptr_d;
  logic                   sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic                   rw_q, rw_d, mack_q, mack_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [ADDRWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   mem_we;
  logic [DATAWIDTH-1:0]   mem_q [DEPTH];
  logic [DATAWIDTH-1:0]   rd_byte;

  assign rd_byte = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= I2C_RW_WRITE;
      mack_q      <= I2C_NACK;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    if (start) begin
      state_d  = DEV;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        DEV, REG, WR: begin
          if (scl_rise && cnt_q != BITS) begin
            shreg_d = {shreg_q[DATAWIDTH-2:0], sda_lvl};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BITS) begin
            cnt_d = '0;
            if (state_q == DEV) begin
              if (shreg_q[DATAWIDTH-1:1] == DEV_ADDR) begin
                state_d  = DACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shreg_q[0];
              end else begin
                state_d = SKIP;
              end
            end else if (state_q == REG) begin
              ptr_d    = shreg_q[ADDRWIDTH-1:0];
              state_d  = RACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d     = WACK;
              sda_oe_d    = 1'b1;
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = shreg_q;
              ptr_d       = ptr_q + ADDRWIDTH'(1);
            end
          end
        end
        // Both ACK phases that can start a read byte share the load path;
        // the pointer advances as each byte is loaded.
        DACK, MACK: begin
          if (state_q == MACK && scl_rise) mack_d = sda_lvl;
          if (scl_fall) begin
            if (state_q == DACK && rw_q == I2C_RW_WRITE) begin
              state_d  = REG;
              sda_oe_d = 1'b0;
            end else if (state_q == MACK && mack_q == I2C_NACK) begin
              state_d = SKIP;
            end else begin
              state_d  = RD;
              shreg_d  = rd_byte;
              sda_oe_d = ~rd_byte[DATAWIDTH-1];
              ptr_d    = ptr_q + ADDRWIDTH'(1);
              cnt_d    = 4'd1;
            end
          end
        end
        RACK, WACK: begin
          if (scl_fall) begin
            state_d  = WR;
            sda_oe_d = 1'b0;
          end
        end
        RD: begin
          if (scl_fall) begin
            if (cnt_q == BITS) begin
              state_d  = MACK;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end else begin
              shreg_d  = shreg_q << 1;
              sda_oe_d = ~shreg_q[DATAWIDTH-2];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-banged initiator, write/read scoreboards and a memory model.
module tb_i2c_target_mem;

  localparam int unsigned Q = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_strobe, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_mem #(
    .DATAWIDTH   (8),
    .ADDRWIDTH   (6),
    .DEV_ADDR    (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  int         strobe_cnt = 0;
  bit         oe_seen = 0;
  bit         busy_seen = 0;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] mem_m [64];
  logic [5:0] mptr = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (reset_n && wr_strobe) begin
      wr_t e;
      strobe_cnt++;
      if (wr_q.size() == 0) begin
        check_eq("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = wr_q.pop_front();
        check_eq("wr_addr", 32'(wr_addr), 32'(e.a));
        check_eq("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    r = sda_line;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
    end
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    logic r;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, r);
      v = {v[6:0], r};
    end
    clk_bit(mack, r);
  endtask

  task automatic addr_byte(input logic [7:0] a, input logic exp_ack, input string tag);
    logic ack;
    send_byte(a, ack);
    check_eq(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic set_ptr(input logic [7:0] p, input string tag);
    addr_byte(p, 1'b0, tag);
    mptr = p[5:0];
  endtask

  task automatic wr_byte(input logic [7:0] d, input string tag);
    wr_q.push_back('{a: mptr, d: d});
    mem_m[mptr] = d;
    mptr = mptr + 6'd1;
    addr_byte(d, 1'b0, tag);
  endtask

  task automatic rd_chk(input logic mack, input string tag);
    logic [7:0] v, e;
    rd_q.push_back(mem_m[mptr]);
    mptr = mptr + 6'd1;
    read_byte(mack, v);
    e = rd_q.pop_front();
    check_eq(tag, 32'(v), 32'(e));
  endtask

  initial begin
    logic [7:0] v;
    logic       r;
    int         s0;

    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;

    // preload 0x0E/0x0F for the pointer follow-up reads
    i2c_start();
    addr_byte(8'hA0, 1'b0, "pre_dev_ack");
    set_ptr(8'h0E, "pre_reg_ack");
    wr_byte(8'h5A, "pre_d0_ack");
    wr_byte(8'hC3, "pre_d1_ack");
    i2c_stop();

    // 1: single write
    s0 = strobe_cnt;
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t1_dev_ack");
    check_eq("t1_busy_high", 32'(busy), 32'd1);
    set_ptr(8'h0D, "t1_reg_ack");
    wr_byte(8'hE5, "t1_data_ack");
    i2c_stop();
    check_eq("t1_busy_low", 32'(busy), 32'd0);
    check_eq("t1_one_strobe", 32'(strobe_cnt - s0), 32'd1);

    // 2: pointer write, repeated START, read, NACK; then pointer continuation
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t2_dev_ack");
    set_ptr(8'h0D, "t2_reg_ack");
    i2c_start();
    addr_byte(8'hA1, 1'b0, "t2_rdev_ack");
    rd_chk(1'b1, "t2_read_0D");
    i2c_stop();
    i2c_start();
    addr_byte(8'hA1, 1'b0, "t2_rdev2_ack");
    rd_chk(1'b0, "t2_read_0E");
    rd_chk(1'b1, "t2_read_0F");
    i2c_stop();

    // 3: wrong address
    s0 = strobe_cnt;
    i2c_start();
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    addr_byte(8'hA2, 1'b1, "t3_nack");
    clk_bit(1'b1, r);
    i2c_stop();
    check_eq("t3_no_oe", 32'(oe_seen), 32'd0);
    check_eq("t3_no_busy", 32'(busy_seen), 32'd0);
    check_eq("t3_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // 4: pointer wrap
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t4_dev_ack");
    set_ptr(8'h3F, "t4_reg_ack");
    wr_byte(8'h11, "t4_d0_ack");
    wr_byte(8'h22, "t4_d1_ack");
    i2c_stop();
    check_eq("t4_wr_drained", 32'(wr_q.size()), 32'd0);
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t4_dev2_ack");
    set_ptr(8'h3F, "t4_reg2_ack");
    i2c_start();
    addr_byte(8'hA1, 1'b0, "t4_rdev_ack");
    rd_chk(1'b0, "t4_read_3F");
    rd_chk(1'b1, "t4_read_00");
    i2c_stop();

    // 5: partial byte then STOP
    s0 = strobe_cnt;
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t5_dev_ack");
    set_ptr(8'h05, "t5_reg_ack");
    clk_bit(1'b1, r);
    clk_bit(1'b0, r);
    clk_bit(1'b1, r);
    clk_bit(1'b0, r);
    i2c_stop();
    check_eq("t5_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t5_next_ack");
    i2c_stop();

    // 6: reset while driving a low read bit
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t6_dev_ack");
    set_ptr(8'h3F, "t6_reg_ack");
    i2c_start();
    addr_byte(8'hA1, 1'b0, "t6_rdev_ack");
    check_eq("t6_driving", 32'(sda_oe), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_release", 32'(sda_oe), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    oe_seen = 1'b0;
    read_byte(1'b1, v);
    check_eq("t6_bus_idle", 32'(v), 32'hFF);
    check_eq("t6_no_oe", 32'(oe_seen), 32'd0);
    check_eq("t6_busy_low", 32'(busy), 32'd0);
    i2c_stop();
    i2c_start();
    addr_byte(8'hA0, 1'b0, "t6_fresh_ack");
    i2c_stop();
    check_eq("end_wr_drained", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
